// File: rtl/branch_target_unit.sv
// Branch target unit: one-deep registered result stage computing relative/absolute
// branch targets, with a circular return-address stack for calls and returns.
module branch_target_unit #(
  parameter int INST_ADDR_WIDTH   = 16,
  parameter int NUM_BYTES_IN_INST = 2,
  parameter int RAS_DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 op,
  input  logic                       jump,
  input  logic [INST_ADDR_WIDTH-1:0] pc,
  input  logic [INST_ADDR_WIDTH-1:0] inst_1,
  input  logic [INST_ADDR_WIDTH-1:0] inst_2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_ADDR_WIDTH-1:0] branch_addr,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [INST_ADDR_WIDTH-1:0] INC      = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
  localparam logic [PTR_W:0]             CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]             CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]           PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    OP_COND = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_JMP  = 2'b11
  } op_e;

  op_e op_s;
  assign op_s = op_e'(op);

  logic                       out_valid_q, out_valid_d;
  logic [INST_ADDR_WIDTH-1:0] branch_addr_q, branch_addr_d;
  logic                       ras_ovf_q, ras_ovf_d;
  logic                       ras_unf_q, ras_unf_d;
  logic [PTR_W-1:0]           top_q, top_d;
  logic [PTR_W:0]             cnt_q, cnt_d;
  logic [INST_ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic                       push_en;
  logic [INST_ADDR_WIDTH-1:0] push_val;
  logic                       accept;

  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign branch_addr = branch_addr_q;
  assign ras_ovf     = ras_ovf_q;
  assign ras_unf     = ras_unf_q;

  always_comb begin
    out_valid_d   = out_valid_q;
    branch_addr_d = branch_addr_q;
    ras_ovf_d     = 1'b0;
    ras_unf_d     = ras_unf_q;
    top_d         = top_q;
    cnt_d         = cnt_q;
    push_en       = 1'b0;
    push_val      = pc + INC;
    if (accept) begin
      out_valid_d = 1'b1;
      case (op_s)
        OP_COND: branch_addr_d = pc + (jump ? inst_1 : inst_2) + INC;
        OP_CALL: begin
          branch_addr_d = pc + inst_1 + INC;
          push_en       = 1'b1;
          top_d         = top_q + PTR_ONE;
          // When full, the slot after top is the oldest entry, so advancing overwrites it.
          if (cnt_q == CNT_FULL) ras_ovf_d = 1'b1;
          else                   cnt_d     = cnt_q + CNT_ONE;
        end
        OP_RET: begin
          if (cnt_q == '0) begin
            branch_addr_d = '0;
            ras_unf_d     = 1'b1;
          end else begin
            branch_addr_d = ras_q[top_q];
            top_d         = top_q - PTR_ONE;
            cnt_d         = cnt_q - CNT_ONE;
          end
        end
        OP_JMP:  branch_addr_d = inst_1;
        default: branch_addr_d = branch_addr_q;
      endcase
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      branch_addr_q <= '0;
      ras_ovf_q     <= 1'b0;
      ras_unf_q     <= 1'b0;
      top_q         <= '0;
      cnt_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      branch_addr_q <= branch_addr_d;
      ras_ovf_q     <= ras_ovf_d;
      ras_unf_q     <= ras_unf_d;
      top_q         <= top_d;
      cnt_q         <= cnt_d;
    end
  end

  // Stack storage carries no reset; occupancy count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_en) ras_q[top_d] <= push_val;
  end

endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 Parameter INST_ADDR_WIDTH, default 16, sets the width of PC, offsets and target address.
REQ-002 Parameter NUM_BYTES_IN_INST, default 2, is the byte increment added to PC for every relative target and return address.
REQ-003 Parameter RAS_DEPTH, default 4 (power of two, >=2), is the number of return-address-stack entries.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted this cycle when in_valid is also high.
REQ-008 op  input  2  00 conditional, 01 call, 10 return, 11 absolute jump.
REQ-009 jump  input  1  conditional outcome; 1 selects inst_1, 0 selects inst_2.
REQ-010 pc, inst_1, inst_2  input  INST_ADDR_WIDTH each  current PC, taken offset/target, not-taken offset.
REQ-011 out_valid  output  1  branch_addr holds a result.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 branch_addr  output  INST_ADDR_WIDTH  registered target address.
REQ-014 ras_ovf  output  1  one-cycle pulse when a call overwrites the oldest stack entry.
REQ-015 ras_unf  output  1  sticky flag, set by a return on an empty stack.

Function
REQ-016 in_ready SHALL equal (!out_valid || out_ready); accept = in_valid && in_ready.
REQ-017 On accept, branch_addr and out_valid=1 SHALL be registered on the same edge; latency exactly 1 cycle.
REQ-018 When out_valid && out_ready and no accept, out_valid SHALL clear at the next edge; branch_addr holds.
REQ-019 While out_valid && !out_ready, branch_addr and out_valid SHALL hold unchanged and no request SHALL be accepted.
REQ-020 op 00: target = pc + (jump ? inst_1 : inst_2) + NUM_BYTES_IN_INST.
REQ-021 op 01: target = pc + inst_1 + NUM_BYTES_IN_INST; push pc + NUM_BYTES_IN_INST onto the stack.
REQ-022 op 10: target = top-of-stack; pop.
REQ-023 op 11: target = inst_1 (absolute); pc and jump ignored.
REQ-024 All additions SHALL be modulo 2^INST_ADDR_WIDTH; carries discarded.
REQ-025 Stack is circular: top pointer log2(RAS_DEPTH) bits wraps; occupancy count 0..RAS_DEPTH.
REQ-026 Call at full occupancy SHALL overwrite the oldest entry, keep count at RAS_DEPTH, pulse ras_ovf for the cycle after acceptance.
REQ-027 Return at zero occupancy SHALL produce target 0, leave pointer and count unchanged, set ras_unf.
REQ-028 A value pushed by a call accepted in cycle N SHALL be the return target for a return accepted in cycle N+1.
REQ-029 Stack, pointer, count and flags SHALL change only on accepted requests; non-accepted inputs have no effect.

Reset
REQ-030 rst low SHALL immediately force out_valid=0, branch_addr=0, ras_ovf=0, ras_unf=0, count=0, pointer=0, regardless of clk.
REQ-031 Stack entry contents need not be reset.
REQ-032 Reset asserted mid-handshake SHALL discard the pending result; first accept after rst rises yields a fresh result one cycle later.
REQ-033 in_ready SHALL be 1 during and immediately after reset.

Verification
REQ-034 op 00, pc=0x0100, inst_1=0x0020, inst_2=0x0004, jump=1 -> next cycle out_valid=1, branch_addr=0x0122; jump=0 -> 0x0106.
REQ-035 op 00, pc=0xFFFE, inst_2=0x0004, jump=0, default width -> branch_addr=0x0004 (wrap).
REQ-036 call pc=0x0200, then return next cycle -> return branch_addr=0x0202, count back to 0.
REQ-037 Five calls at pc=0x10,0x20,0x30,0x40,0x50 with RAS_DEPTH=4 -> ras_ovf pulse after fifth; four returns yield 0x52,0x42,0x32,0x22; fifth return yields 0 and sets ras_unf.
REQ-038 Result held with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, branch_addr stable, stack unchanged; out_ready=1 -> queued request accepted same cycle.
REQ-039 rst pulled low between clock edges with out_valid=1 -> out_valid and branch_addr 0 before next edge; ras_unf cleared.
